// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard_if
//  Description : Issue, writeback, flush and status bundle between the
//                decode stage and the register-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if;

   // Issue side: instruction presented by decode
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_rs1;
   logic        issue_rs1_used;
   logic [4:0]  issue_rs2;
   logic        issue_rs2_used;
   logic [4:0]  issue_rd;
   logic        issue_wr;

   // Writeback side: one retired register write per cycle
   logic        wb_valid;
   logic [4:0]  wb_rd;

   // Pipeline control
   logic        flush;

   // Status
   logic [31:0] busy_mask;
   logic        wb_underflow;
   logic [31:0] stall_cycles;

   // Pipeline side: drives issue/writeback/flush, observes status
   modport master (
      output issue_valid,
      output issue_rs1,
      output issue_rs1_used,
      output issue_rs2,
      output issue_rs2_used,
      output issue_rd,
      output issue_wr,
      output wb_valid,
      output wb_rd,
      output flush,
      input  issue_ready,
      input  busy_mask,
      input  wb_underflow,
      input  stall_cycles
   );

   // Scoreboard side
   modport slave (
      input  issue_valid,
      input  issue_rs1,
      input  issue_rs1_used,
      input  issue_rs2,
      input  issue_rs2_used,
      input  issue_rd,
      input  issue_wr,
      input  wb_valid,
      input  wb_rd,
      input  flush,
      output issue_ready,
      output busy_mask,
      output wb_underflow,
      output stall_cycles
   );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Register-write scoreboard for the in-order RV64I pipeline.
//                Tracks in-flight writers per architectural register and
//                gates issue on RAW hazards and per-register writer
//                saturation (WAW resource limit).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
   parameter int CNT_W = 2
) (
   input  wire              clk,
   input  wire              reset,   // asynchronous, active low
   reg_scoreboard_if.slave  sb
);

   // ------------------------------------------------------------------------
   // Per-register status vectors. Bit 0 (x0) is tied off: x0 is never
   // tracked, never pending and never saturated.
   // ------------------------------------------------------------------------
   wire [31:0]  w_busy;
   wire [31:0]  w_sat;

   logic        w_rs1_hazard;
   logic        w_rs2_hazard;
   logic        w_rd_full;
   logic        w_issue_ready;
   logic        w_issue_wr_fire;
   logic        w_wb_live;
   logic        w_wb_underflow_evt;

   logic        r_wb_underflow;
   logic [31:0] r_stall_cycles;

   assign w_busy[0] = 1'b0;
   assign w_sat[0]  = 1'b0;

   // ------------------------------------------------------------------------
   // Issue gating. Only registered counters, flush and the issue inputs feed
   // this path; a writeback in the same cycle does not release a hazard
   // until the following cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rs1_hazard  = sb.issue_rs1_used && w_busy[sb.issue_rs1];
      w_rs2_hazard  = sb.issue_rs2_used && w_busy[sb.issue_rs2];
      w_rd_full     = sb.issue_wr && w_sat[sb.issue_rd];
      w_issue_ready = !sb.flush && !w_rs1_hazard && !w_rs2_hazard && !w_rd_full;
   end

   // ------------------------------------------------------------------------
   // Event qualification shared by all counters. A flush cycle discards both
   // the issue (already blocked by ready) and any writeback.
   // ------------------------------------------------------------------------
   always_comb begin
      w_issue_wr_fire    = sb.issue_valid && w_issue_ready && sb.issue_wr;
      w_wb_live          = sb.wb_valid && !sb.flush;
      w_wb_underflow_evt = w_wb_live && (sb.wb_rd != 5'd0) && !w_busy[sb.wb_rd];
   end

   // ------------------------------------------------------------------------
   // One in-flight-writer counter per register x1..x31.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;
         logic             w_inc;
         logic             w_dec;

         // Decrement only when a writer is actually outstanding; a writeback
         // to an idle register is the underflow case and leaves the count 0.
         always_comb begin
            w_inc = w_issue_wr_fire && (sb.issue_rd == 5'(gi));
            w_dec = w_wb_live && (sb.wb_rd == 5'(gi)) && (r_cnt != '0);
         end

         // Counter update: flush clears, simultaneous inc/dec cancel out
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_cnt <= '0;
            end else if (sb.flush) begin
               r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end

         assign w_busy[gi] = |r_cnt;
         assign w_sat[gi]  = &r_cnt;
      end
   endgenerate

   // Sticky underflow flag: set by a writeback with no outstanding writer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wb_underflow <= 1'b0;
      end else if (w_wb_underflow_evt) begin
         r_wb_underflow <= 1'b1;
      end
   end

   // Saturating count of cycles where decode was held off
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
      end else if (sb.issue_valid && !w_issue_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign sb.issue_ready  = w_issue_ready;
   assign sb.busy_mask    = w_busy;
   assign sb.wb_underflow = r_wb_underflow;
   assign sb.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard. A reference model
//                predicts ready/busy/underflow/stall for every driven cycle;
//                predictions are queued at drive time and compared when the
//                DUT outputs settle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_scoreboard;

   localparam int MAXC = 3;   // all-ones for CNT_W = 2

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   reg_scoreboard_if sb_if ();

   reg_scoreboard #(.CNT_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   typedef struct {
      string       tag;
      logic        rdy;
      logic [31:0] busy;
      logic        uf;
      logic [31:0] st;
   } exp_t;

   exp_t        expq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          mcnt[32];
   logic        muf;
   logic [31:0] mst;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] m;
      m = '0;
      for (int i = 1; i < 32; i++) m[i] = (mcnt[i] != 0);
      return m;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      muf = 1'b0;
      mst = '0;
   endtask

   // One clock cycle: called at a falling edge, returns at the next one.
   task automatic cycle(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic wr,
                        input logic wbv, input logic [4:0] wbr,
                        input logic fl, input string tag);
      exp_t e;
      exp_t o;
      logic rdy;
      int   pre;
      sb_if.issue_valid    = v;
      sb_if.issue_rs1      = r1;
      sb_if.issue_rs1_used = u1;
      sb_if.issue_rs2      = r2;
      sb_if.issue_rs2_used = u2;
      sb_if.issue_rd       = rd;
      sb_if.issue_wr       = wr;
      sb_if.wb_valid       = wbv;
      sb_if.wb_rd          = wbr;
      sb_if.flush          = fl;
      rdy = !fl && !(u1 && r1 != 0 && mcnt[r1] != 0)
                && !(u2 && r2 != 0 && mcnt[r2] != 0)
                && !(wr && rd != 0 && mcnt[rd] == MAXC);
      e.tag  = tag;
      e.rdy  = rdy;
      e.busy = model_busy();
      e.uf   = muf;
      e.st   = mst;
      expq.push_back(e);
      #1;
      o = expq.pop_front();
      check_val({o.tag, ".ready"}, 32'(sb_if.issue_ready),  32'(o.rdy));
      check_val({o.tag, ".busy"},  sb_if.busy_mask,         o.busy);
      check_val({o.tag, ".uflow"}, 32'(sb_if.wb_underflow), 32'(o.uf));
      check_val({o.tag, ".stall"}, sb_if.stall_cycles,      o.st);
      @(posedge clk);
      if (reset === 1'b0) begin
         model_clear();
      end else begin
         if (v && !rdy && mst != 32'hFFFF_FFFF) mst = mst + 32'd1;
         if (fl) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
         end else begin
            pre = (wbr != 0) ? mcnt[wbr] : 0;
            if (v && rdy && wr && rd != 0) mcnt[rd]++;
            if (wbv && wbr != 0) begin
               if (pre == 0) muf = 1'b1;
               else          mcnt[wbr]--;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   task automatic iss(input logic [4:0] rd, input string tag);
      cycle(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, tag);
   endtask

   task automatic wb(input logic [4:0] r, input string tag);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, r, 0, tag);
   endtask

   initial begin
      model_clear();
      sb_if.issue_valid = 0; sb_if.issue_rs1 = 0; sb_if.issue_rs1_used = 0;
      sb_if.issue_rs2 = 0;   sb_if.issue_rs2_used = 0; sb_if.issue_rd = 0;
      sb_if.issue_wr = 0;    sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.flush = 0;

      // Reset state: ready follows !flush
      @(negedge clk); #1;
      check_val("rst.ready",  32'(sb_if.issue_ready),  32'd1);
      check_val("rst.busy",   sb_if.busy_mask,         32'd0);
      check_val("rst.uflow",  32'(sb_if.wb_underflow), 32'd0);
      check_val("rst.stall",  sb_if.stall_cycles,      32'd0);
      sb_if.flush = 1; #1;
      check_val("rst.flush_ready", 32'(sb_if.issue_ready), 32'd0);
      sb_if.flush = 0;
      @(negedge clk);
      reset = 1'b1;
      idle("post_rst");

      // Basic RAW stall and release
      iss(5, "raw_iss");
      check_val("raw.busy20", sb_if.busy_mask, 32'h0000_0020);
      cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "raw_st1");
      cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "raw_st2");
      cycle(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, "raw_st3_wb");
      cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "raw_go");
      check_val("raw.stall3", sb_if.stall_cycles, 32'd3);

      // x0 handling
      iss(0, "x0_iss");
      check_val("x0.busy", sb_if.busy_mask, 32'd0);
      cycle(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, "x0_src");
      wb(0, "x0_wb");
      check_val("x0.uflow", 32'(sb_if.wb_underflow), 32'd0);

      // Saturation at three writers
      iss(7, "sat_i1");
      iss(7, "sat_i2");
      iss(7, "sat_i3");
      cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, "sat_block");
      cycle(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, "sat_wb");
      cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, "sat_go");
      cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, "sat_full");
      wb(7, "sat_d1");
      wb(7, "sat_d2");
      wb(7, "sat_d3");
      check_val("sat.drained", sb_if.busy_mask, 32'd0);

      // Simultaneous events
      iss(9, "sim_i9");
      cycle(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, "sim_same");
      check_val("sim.same_busy", sb_if.busy_mask, 32'h0000_0200);
      cycle(1, 0, 0, 0, 0, 10, 1, 1, 9, 0, "sim_diff");
      check_val("sim.diff_busy", sb_if.busy_mask, 32'h0000_0400);
      wb(10, "sim_d10");

      // Flush
      iss(3, "fl_i3a");
      iss(3, "fl_i3b");
      iss(4, "fl_i4");
      check_val("fl.pre_busy", sb_if.busy_mask, 32'h0000_0018);
      cycle(1, 0, 0, 0, 0, 6, 1, 1, 3, 1, "fl_cyc");
      check_val("fl.post_busy", sb_if.busy_mask, 32'd0);
      cycle(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, "fl_rd6_free");

      // Back-to-back independent issues
      for (int i = 1; i <= 8; i++) cycle(1, 5'(i + 16), 1, 5'(i + 20), 1, 5'(i), 1, 0, 0, 0, "b2b");
      check_val("b2b.busy", sb_if.busy_mask, 32'h0000_01FE);
      for (int i = 1; i <= 8; i++) wb(5'(i), "b2b_wb");

      // Underflow, sticky
      wb(12, "uf_wb");
      check_val("uf.set", 32'(sb_if.wb_underflow), 32'd1);
      idle("uf_hold");
      check_val("uf.sticky", 32'(sb_if.wb_underflow), 32'd1);

      // Random traffic against the model
      for (int k = 0; k < 80; k++) begin
         cycle(1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 29) == 0), "rnd");
      end

      // Asynchronous reset mid-operation
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "ar_flush");
      iss(5, "ar_i1");
      iss(5, "ar_i2");
      cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "ar_stall");
      check_val("ar.pre_busy", sb_if.busy_mask, 32'h0000_0020);
      #2 reset = 1'b0;
      #1;
      check_val("ar.busy",  sb_if.busy_mask,         32'd0);
      check_val("ar.uflow", 32'(sb_if.wb_underflow), 32'd0);
      check_val("ar.stall", sb_if.stall_cycles,      32'd0);
      check_val("ar.ready", 32'(sb_if.issue_ready),  32'd1);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      idle("ar_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
